// File: rtl/ysyx_22050019_mdu_pkg.sv
// Shared definitions for the RV64 M-extension multiply/divide unit:
// datapath width, funct3 op codes, FSM state encoding and iteration counts.
package ysyx_22050019_mdu_pkg;

    localparam int MDU_XLEN  = 64;
    localparam int MDU_CNT_W = 7;

    localparam logic [MDU_CNT_W-1:0] MDU_ITER_64 = 7'd64;
    localparam logic [MDU_CNT_W-1:0] MDU_ITER_32 = 7'd32;
    localparam logic [MDU_CNT_W-1:0] MDU_CNT_ONE = 7'd1;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/ysyx_22050019_mdu_div.sv
// Restoring divider core on unsigned magnitudes, one quotient bit per step.
// quot_o/rem_o present the values produced by the step taken this cycle.
module ysyx_22050019_mdu_div
    import ysyx_22050019_mdu_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  logic            clk,
    input  logic            start_i,
    input  logic            step_i,
    input  logic            last_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            done_o,
    output logic [XLEN-1:0] quot_o,
    output logic [XLEN-1:0] rem_o
);

    logic [XLEN-1:0] rem_q, quot_q, dsor_q;
    logic [XLEN:0]   trial;
    logic            fits;

    // The partial remainder is always below the divisor, so the subtraction
    // can be done modulo 2^XLEN once the wide compare has succeeded.
    always_comb begin
        trial  = {rem_q, quot_q[XLEN-1]};
        fits   = (trial >= {1'b0, dsor_q});
        rem_o  = fits ? (trial[XLEN-1:0] - dsor_q) : trial[XLEN-1:0];
        quot_o = {quot_q[XLEN-2:0], fits};
    end

    assign done_o = step_i & last_i;

    always_ff @(posedge clk) begin
        if (start_i) begin
            rem_q  <= '0;
            quot_q <= dividend_i;
            dsor_q <= divisor_i;
        end else if (step_i) begin
            rem_q  <= rem_o;
            quot_q <= quot_o;
        end
    end

endmodule

// File: rtl/ysyx_22050019_mdu.sv
// Iterative RV64 M-extension unit: shift-add multiplier and restoring divider,
// one bit per cycle, stalling the EX stage until the registered result is ready.
module ysyx_22050019_mdu
    import ysyx_22050019_mdu_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [2:0]      op_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic            ex_stall_i,
    input  logic            flush_i,
    output logic            alu_stall_req_o,
    output logic [XLEN-1:0] result_o,
    output logic            result_valid_o
);

    localparam int PW = 2 * XLEN;

    function automatic logic [XLEN-1:0] sext_w(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] zext_w(input logic [31:0] v);
        return {{(XLEN-32){1'b0}}, v};
    endfunction

    mdu_state_e            state_q, state_d;
    logic [MDU_CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]       result_q, result_d;
    logic [2:0]            op_q;
    logic                  word_q, neg_q;
    logic [PW-1:0]         acc_q, acc_d, mcand_q, mcand_d;
    logic [XLEN-1:0]       mplier_q, mplier_d;
    logic                  load;

    logic [2:0]      op_eff;
    logic            sgn1, sgn2, neg1, neg2, neg_res, is_div, div_zero, div_ovf;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val, special_res, div_dividend;

    logic            div_start, div_step, div_last, div_done;
    logic [XLEN-1:0] div_quot, div_rem, div_sel, div_fix, raw_res, final_res;
    logic [PW-1:0]   mul_acc_nxt, prod;
    logic            last_iter;

    // Illegal word forms of mulh/mulhsu/mulhu fold onto mulw.
    always_comb begin
        op_eff = (word_i && !op_i[2]) ? OP_MUL : op_i;
        sgn1   = (op_eff == OP_MULH) || (op_eff == OP_MULHSU) ||
                 (op_eff == OP_DIV)  || (op_eff == OP_REM);
        sgn2   = (op_eff == OP_MULH) || (op_eff == OP_DIV) || (op_eff == OP_REM);
        a_ext  = word_i ? (sgn1 ? sext_w(src1_i[31:0]) : zext_w(src1_i[31:0])) : src1_i;
        b_ext  = word_i ? (sgn2 ? sext_w(src2_i[31:0]) : zext_w(src2_i[31:0])) : src2_i;
        neg1   = sgn1 & a_ext[XLEN-1];
        neg2   = sgn2 & b_ext[XLEN-1];
        a_mag  = neg1 ? -a_ext : a_ext;
        b_mag  = neg2 ? -b_ext : b_ext;
        is_div = op_eff[2];

        // Quotient sign is the XOR of operand signs; remainder follows the dividend.
        neg_res  = (is_div && op_eff[1]) ? neg1 : (neg1 ^ neg2);
        min_val  = word_i ? sext_w(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = is_div && (b_ext == '0);
        div_ovf  = is_div && sgn1 && (a_ext == min_val) && (b_ext == '1);

        if (div_zero) begin
            special_res = op_eff[1] ? a_ext : '1;
        end else begin
            special_res = op_eff[1] ? '0 : a_ext;
        end
        if (word_i) begin
            special_res = sext_w(special_res[31:0]);
        end

        // Word divides run 32 steps, so the dividend must enter MSB-first.
        div_dividend = word_i ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;
    end

    ysyx_22050019_mdu_div #(
        .XLEN(XLEN)
    ) u_div (
        .clk        (clk),
        .start_i    (div_start),
        .step_i     (div_step),
        .last_i     (div_last),
        .dividend_i (div_dividend),
        .divisor_i  (b_mag),
        .done_o     (div_done),
        .quot_o     (div_quot),
        .rem_o      (div_rem)
    );

    assign div_last  = (cnt_q == MDU_CNT_ONE);
    assign last_iter = op_q[2] ? div_done : (cnt_q == MDU_CNT_ONE);

    always_comb begin
        mul_acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
        prod        = neg_q ? -mul_acc_nxt : mul_acc_nxt;
        div_sel     = op_q[1] ? div_rem : div_quot;
        div_fix     = neg_q ? -div_sel : div_sel;
        if (op_q[2]) begin
            raw_res = div_fix;
        end else if (op_q == OP_MUL) begin
            raw_res = prod[XLEN-1:0];
        end else begin
            raw_res = prod[PW-1:XLEN];
        end
        final_res = word_q ? sext_w(raw_res[31:0]) : raw_res;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        load      = 1'b0;
        div_start = 1'b0;
        div_step  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (valid_i && !flush_i) begin
                    load = 1'b1;
                    if (div_zero || div_ovf) begin
                        state_d  = ST_DONE;
                        result_d = special_res;
                    end else begin
                        state_d   = ST_BUSY;
                        cnt_d     = word_i ? MDU_ITER_32 : MDU_ITER_64;
                        acc_d     = '0;
                        mcand_d   = {{XLEN{1'b0}}, a_mag};
                        mplier_d  = b_mag;
                        div_start = is_div;
                    end
                end
            end
            ST_BUSY: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - MDU_CNT_ONE;
                    if (op_q[2]) begin
                        div_step = 1'b1;
                    end else begin
                        acc_d    = mul_acc_nxt;
                        mcand_d  = mcand_q << 1;
                        mplier_d = mplier_q >> 1;
                    end
                    if (last_iter) begin
                        state_d  = ST_DONE;
                        result_d = final_res;
                    end
                end
            end
            ST_DONE: begin
                if (flush_i || !ex_stall_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    always_ff @(posedge clk) begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        if (load) begin
            op_q   <= op_eff;
            word_q <= word_i;
            neg_q  <= neg_res;
        end
    end

    assign alu_stall_req_o = ((state_q == ST_IDLE) && valid_i && !flush_i) ||
                             (state_q == ST_BUSY);
    assign result_o        = result_q;
    assign result_valid_o  = (state_q == ST_DONE);

endmodule

// File: tb/tb_ysyx_22050019_mdu.sv
// Scoreboard bench for the M-extension unit: a driver issues ops and queues the
// expected result/latency; a monitor checks every result_valid_o window.
`timescale 1ns/1ps
module tb_ysyx_22050019_mdu;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, word_i, ex_stall_i, flush_i;
    logic [2:0]  op_i;
    logic [63:0] src1_i, src2_i;
    logic        alu_stall_req_o, result_valid_o;
    logic [63:0] result_o;

    always #5 clk = ~clk;

    ysyx_22050019_mdu #(.XLEN(64)) dut (
        .clk             (clk),
        .rst             (rst),
        .valid_i         (valid_i),
        .op_i            (op_i),
        .word_i          (word_i),
        .src1_i          (src1_i),
        .src2_i          (src2_i),
        .ex_stall_i      (ex_stall_i),
        .flush_i         (flush_i),
        .alu_stall_req_o (alu_stall_req_o),
        .result_o        (result_o),
        .result_valid_o  (result_valid_o)
    );

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          hold;
        int          issue;
    } item_t;

    item_t sb_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Reference: full-width arithmetic on the architectural operand values.
    function automatic logic [63:0] ref_result(input logic [2:0] op_in, input logic w,
                                               input logic [63:0] a, input logic [63:0] b,
                                               output int lat);
        logic [2:0]      op;
        logic [127:0]    pa, pb, p;
        longint          sx, sy, smin;
        longint unsigned ux, uy;
        logic [63:0]     q, rm, r;
        logic            special;
        op      = (w && !op_in[2]) ? 3'b000 : op_in;
        special = 1'b0;
        q       = '0;
        rm      = '0;
        if (!op[2]) begin
            pa = (op == 3'b001 || op == 3'b010) ? {{64{a[63]}}, a} : {64'b0, a};
            pb = (op == 3'b001) ? {{64{b[63]}}, b} : {64'b0, b};
            p  = pa * pb;
            r  = (op == 3'b000) ? p[63:0] : p[127:64];
        end else if (!op[0]) begin
            sx   = w ? longint'(sx32(a[31:0])) : longint'(a);
            sy   = w ? longint'(sx32(b[31:0])) : longint'(b);
            smin = w ? longint'(sx32(32'h8000_0000)) : longint'(64'h8000_0000_0000_0000);
            if (sy == 0) begin
                q = '1; rm = sx; special = 1'b1;
            end else if (sy == -1 && sx == smin) begin
                q = sx; rm = '0; special = 1'b1;
            end else begin
                q = sx / sy; rm = sx % sy;
            end
            r = op[1] ? rm : q;
        end else begin
            ux = w ? {32'b0, a[31:0]} : a;
            uy = w ? {32'b0, b[31:0]} : b;
            if (uy == 0) begin
                q = '1; rm = ux; special = 1'b1;
            end else begin
                q = ux / uy; rm = ux % uy;
            end
            r = op[1] ? rm : q;
        end
        if (w) r = sx32(r[31:0]);
        lat = special ? 1 : (w ? 33 : 65);
        return r;
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0:       return 64'h0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'hFFFF_FFFF_8000_0000;
            4:       return {32'h0, $urandom};
            5:       return {32'h0, $urandom_range(0, 20)};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Monitor: one pop per rising result_valid_o, then hold/length checks.
    initial begin : monitor
        item_t cur;
        logic  cur_ok    = 1'b0;
        logic  rv_prev   = 1'b0;
        int    rv_len    = 0;
        int    stall_run = 0;
        forever begin
            @(negedge clk);
            if (result_valid_o && !rv_prev) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_result_valid", 64'(result_valid_o), 64'd0);
                    cur_ok = 1'b0;
                end else begin
                    cur    = sb_q.pop_front();
                    cur_ok = 1'b1;
                    chk("result", result_o, cur.res);
                    chk("latency", 64'(cyc - cur.issue), 64'(cur.lat));
                    chk("stall_cycles", 64'(stall_run), 64'(cur.lat));
                end
                chk("stall_in_done", 64'(alu_stall_req_o), 64'd0);
                rv_len    = 1;
                stall_run = 0;
            end else if (result_valid_o) begin
                rv_len++;
                if (cur_ok) chk("hold_result", result_o, cur.res);
                chk("stall_in_done", 64'(alu_stall_req_o), 64'd0);
            end else if (rv_prev && cur_ok) begin
                chk("valid_len", 64'(rv_len), 64'(cur.hold));
            end
            if (alu_stall_req_o) stall_run++;
            else if (!result_valid_o && !valid_i) stall_run = 0;
            if (rst) stall_run = 0;
            rv_prev = result_valid_o;
        end
    end

    task automatic drive(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
        valid_i = 1'b1; op_i = op; word_i = w; src1_i = a; src2_i = b;
        ex_stall_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic start_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                            input logic [63:0] b, input int hold);
        item_t it;
        int    lat;
        it.res   = ref_result(op, w, a, b, lat);
        it.lat   = lat;
        it.hold  = hold + 1;
        it.issue = cyc;
        sb_q.push_back(it);
        drive(op, w, a, b);
    endtask

    task automatic wait_done(input int hold);
        int budget = 0;
        @(negedge clk);
        while (!result_valid_o && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (!result_valid_o) begin
            chk("done_timeout", 64'(result_valid_o), 64'd1);
            sb_q.delete();
            rst = 1'b1; valid_i = 1'b0;
            @(posedge clk); #2 rst = 1'b0;
            @(posedge clk); #1;
            return;
        end
        ex_stall_i = (hold > 0);
        for (int i = 0; i < hold; i++) @(negedge clk);
        ex_stall_i = 1'b0;
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic run(input logic [2:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input int hold);
        start_op(op, w, a, b, hold);
        wait_done(hold);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [2:0]  op;
        logic        w;
        logic [63:0] a, b;
        rst = 1'b1; valid_i = 1'b0; op_i = '0; word_i = 1'b0;
        src1_i = '0; src2_i = '0; ex_stall_i = 1'b0; flush_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_result", result_o, 64'd0);
        chk("reset_valid", 64'(result_valid_o), 64'd0);
        chk("reset_stall", 64'(alu_stall_req_o), 64'd0);
        valid_i = 1'b1;
        #1 chk("reset_stall_follows_valid", 64'(alu_stall_req_o), 64'd1);
        valid_i = 1'b0;
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); #1;

        run(3'b000, 1'b0, 64'd7, -64'sd3, 0);
        run(3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0);
        run(3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run(3'b100, 1'b0, 64'd100, 64'd0, 0);
        run(3'b110, 1'b0, -64'sd7, 64'd2, 0);
        run(3'b111, 1'b1, 64'h1_0000_0009, 64'd4, 0);
        run(3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run(3'b010, 1'b0, -64'sd5, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run(3'b000, 1'b0, 64'd12345, 64'd678, 3);
        run(3'b100, 1'b0, 64'd10, 64'd0, 2);

        // Flush at BUSY cycle 10: the op must vanish without a result.
        drive(3'b001, 1'b0, 64'd99, 64'd77);
        repeat (10) @(posedge clk);
        #1 flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0; valid_i = 1'b0;
        chk("flush_busy_stall", 64'(alu_stall_req_o), 64'd0);
        chk("flush_busy_valid", 64'(result_valid_o), 64'd0);
        // Flush wins over valid_i in IDLE.
        drive(3'b101, 1'b0, 64'd50, 64'd7);
        flush_i = 1'b1;
        #1 chk("flush_idle_stall", 64'(alu_stall_req_o), 64'd0);
        @(posedge clk); #1;
        flush_i = 1'b0; valid_i = 1'b0;
        chk("flush_idle_valid", 64'(result_valid_o), 64'd0);
        repeat (70) @(posedge clk);
        #1;

        // Reset mid-BUSY clears every output at once.
        run(3'b000, 1'b0, 64'd5, 64'd6, 0);
        drive(3'b000, 1'b0, 64'd11, 64'd13);
        repeat (6) @(posedge clk);
        #3 valid_i = 1'b0; rst = 1'b1;
        #1;
        chk("rst_busy_result", result_o, 64'd0);
        chk("rst_busy_valid", 64'(result_valid_o), 64'd0);
        chk("rst_busy_stall", 64'(alu_stall_req_o), 64'd0);
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); #1;

        // Reset with valid_i still high: a fresh op starts after release.
        drive(3'b110, 1'b0, -64'sd1000, 64'd7);
        repeat (6) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        start_op(3'b110, 1'b0, -64'sd1000, 64'd7, 0);
        wait_done(0);

        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 7));
            w  = 1'($urandom_range(0, 1));
            a  = pick();
            b  = pick();
            run(op, w, a, b, $urandom_range(0, 2));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) @(posedge clk);
        #1 chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
